// File: rtl/soc_axi_pkg.sv
// soc_axi_pkg: shared AXI4-Lite widths, arbiter state and master-id types
package soc_axi_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} arb_state_e;
  typedef enum logic {MID_M0 = 1'b0, MID_M1 = 1'b1} master_id_e;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-input round-robin grant, pointer moves only when a transaction completes
// clk, rst_n : clock, async active-low reset (pointer favours m0)
// i_req      : request per master
// i_done     : current owner finished its transaction
// i_owner    : master that just finished
// o_gnt      : one-hot combinational grant, 00 when nobody requests
module rr_arbiter_2
  import soc_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  master_id_e i_owner,
  output logic [1:0] o_gnt
);
  master_id_e r_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= MID_M0;
    else if (i_done) r_ptr <= (i_owner == MID_M0) ? MID_M1 : MID_M0;
  assign o_gnt = (i_req == 2'b11) ? ((r_ptr == MID_M1) ? 2'b10 : 2'b01) : i_req;
endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// axi_lite_arbiter_2to1: shares one AXI4-Lite slave between two masters, one whole transaction at a time
// clk, rst_n   : system clock, async active-low reset
// m0_*, m1_*   : AXI4-Lite slave-side ports toward the two masters
// s_*          : AXI4-Lite master-side port toward the shared slave
// grant_o      : one-hot owner of the current transaction, 00 when idle
module axi_lite_arbiter_2to1
  import soc_axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [1:0]          grant_o
);
  arb_state_e r_state;
  logic [1:0] r_grant;
  logic       r_aw_done, r_w_done;
  logic       w_sel, w_wr, w_wresp, w_rdaddr, w_rddata;
  logic       w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic       w_awrdy, w_wrdy, w_bval, w_arrdy, w_rval;
  logic       w_aw_all, w_w_all, w_done;
  logic [1:0] w_req, w_gnt;
  // r_grant is 00 outside a transaction, so every per-master output gated by it is idle-safe
  assign w_sel     = r_grant[1];
  assign w_wr      = (r_state == WR);
  assign w_wresp   = (r_state == WR_RESP);
  assign w_rdaddr  = (r_state == RD_ADDR);
  assign w_rddata  = (r_state == RD_DATA);
  assign w_awvalid = w_sel ? m1_awvalid : m0_awvalid;
  assign w_wvalid  = w_sel ? m1_wvalid : m0_wvalid;
  assign w_bready  = w_sel ? m1_bready : m0_bready;
  assign w_arvalid = w_sel ? m1_arvalid : m0_arvalid;
  assign w_rready  = w_sel ? m1_rready : m0_rready;
  assign s_awaddr  = w_sel ? m1_awaddr : m0_awaddr;
  assign s_wdata   = w_sel ? m1_wdata : m0_wdata;
  assign s_wstrb   = w_sel ? m1_wstrb : m0_wstrb;
  assign s_araddr  = w_sel ? m1_araddr : m0_araddr;
  assign s_awvalid = w_wr & w_awvalid & ~r_aw_done;
  assign s_wvalid  = w_wr & w_wvalid & ~r_w_done;
  assign s_bready  = w_wresp & w_bready;
  assign s_arvalid = w_rdaddr & w_arvalid;
  assign s_rready  = w_rddata & w_rready;
  assign w_awrdy   = w_wr & s_awready & ~r_aw_done;
  assign w_wrdy    = w_wr & s_wready & ~r_w_done;
  assign w_bval    = w_wresp & s_bvalid;
  assign w_arrdy   = w_rdaddr & s_arready;
  assign w_rval    = w_rddata & s_rvalid;
  assign m0_awready = r_grant[0] & w_awrdy;
  assign m0_wready  = r_grant[0] & w_wrdy;
  assign m0_bvalid  = r_grant[0] & w_bval;
  assign m0_arready = r_grant[0] & w_arrdy;
  assign m0_rvalid  = r_grant[0] & w_rval;
  assign m0_rdata   = r_grant[0] ? s_rdata : '0;
  assign m1_awready = r_grant[1] & w_awrdy;
  assign m1_wready  = r_grant[1] & w_wrdy;
  assign m1_bvalid  = r_grant[1] & w_bval;
  assign m1_arready = r_grant[1] & w_arrdy;
  assign m1_rvalid  = r_grant[1] & w_rval;
  assign m1_rdata   = r_grant[1] ? s_rdata : '0;
  assign grant_o    = r_grant;
  // AW and W complete independently; a flag remembers a phase that finished earlier
  assign w_aw_all = r_aw_done | (s_awvalid & s_awready);
  assign w_w_all  = r_w_done | (s_wvalid & s_wready);
  assign w_done   = (w_wresp & s_bvalid & s_bready) | (w_rddata & s_rvalid & s_rready);
  assign w_req    = {m1_awvalid | m1_arvalid, m0_awvalid | m0_arvalid};
  rr_arbiter_2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (w_req),
    .i_done  (w_done),
    .i_owner (w_sel ? MID_M1 : MID_M0),
    .o_gnt   (w_gnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_grant <= w_gnt;
          r_state <= (w_gnt[1] ? m1_awvalid : m0_awvalid) ? WR : RD_ADDR;
        end
        WR: if (w_aw_all & w_w_all) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_state   <= WR_RESP;
        end else begin
          r_aw_done <= w_aw_all;
          r_w_done  <= w_w_all;
        end
        WR_RESP: if (s_bvalid & s_bready) begin
          r_state <= IDLE;
          r_grant <= '0;
        end
        RD_ADDR: if (s_arvalid & s_arready) r_state <= RD_DATA;
        RD_DATA: if (s_rvalid & s_rready) begin
          r_state <= IDLE;
          r_grant <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// tb_axi_lite_arbiter_2to1: directed scoreboard bench for the 2:1 AXI4-Lite arbiter
module tb_axi_lite_arbiter_2to1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] m0_awaddr, m0_araddr, m0_wdata, m0_rdata, m1_awaddr, m1_araddr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready, m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready, m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0] grant_o;
  axi_lite_arbiter_2to1 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_o(grant_o)
  );
  int total = 0, bad = 0, cyc = 0, b0_cyc = 0, g1_cyc = 0;
  int aw_stall = 0, r_delay = 0;
  logic [31:0] rd_val = '0;
  logic [31:0] q_aw[$], q_ar[$];
  logic [35:0] q_w[$];
  logic        q_b[$];
  logic [32:0] q_r[$];
  logic [1:0]  q_g[$];
  logic [1:0]  prev_g = 2'b00;
  assign s_awready = (aw_stall == 0);
  assign s_wready  = 1'b1;
  assign s_arready = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [14:0] all_vr();
    return {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid,
            m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid,
            s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
  endfunction
  // slave model: AW stalls aw_stall cycles, B follows AW+W, R follows AR after r_delay
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_wait, got_aw, got_w, r_pend;
    int r_cnt;
    s_bvalid = 0; s_rvalid = 0; s_rdata = '0; got_aw = 0; got_w = 0; r_pend = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      aw_hs = s_awvalid && s_awready; w_hs = s_wvalid && s_wready; b_hs = s_bvalid && s_bready;
      ar_hs = s_arvalid && s_arready; r_hs = s_rvalid && s_rready; aw_wait = s_awvalid && !s_awready;
      @(posedge clk); #1;
      if (!rst_n) begin
        s_bvalid = 0; s_rvalid = 0; got_aw = 0; got_w = 0; r_pend = 0;
      end else begin
        if (aw_wait && aw_stall > 0) aw_stall--;
        if (aw_hs) got_aw = 1;
        if (w_hs) got_w = 1;
        if (b_hs) s_bvalid = 0;
        if (got_aw && got_w) begin s_bvalid = 1; got_aw = 0; got_w = 0; end
        if (r_hs) begin s_rvalid = 0; s_rdata = '0; end
        if (ar_hs) begin r_pend = 1; r_cnt = r_delay; end
        else if (r_pend) begin
          if (r_cnt <= 1) begin s_rvalid = 1; s_rdata = rd_val; r_pend = 0; end
          else r_cnt--;
        end
      end
    end
  end
  // monitor: pops expectations whenever the DUT presents a handshake or a new grant
  always @(negedge clk) begin
    if (!rst_n) prev_g = 2'b00;
    else begin
      if (!grant_o[0]) check("m0_isolated", {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid, m0_rdata}, 0);
      if (!grant_o[1]) check("m1_isolated", {m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid, m1_rdata}, 0);
      check("grant_onehot", grant_o != 2'b11, 1);
      if (prev_g == 2'b00 && grant_o != 2'b00) begin
        check("grant_expected", q_g.size() != 0, 1);
        if (q_g.size() != 0) check("grant_value", grant_o, q_g.pop_front());
        if (grant_o == 2'b10) g1_cyc = cyc;
      end
      prev_g = grant_o;
      if (s_awvalid && s_awready) begin
        check("aw_expected", q_aw.size() != 0, 1);
        if (q_aw.size() != 0) check("s_awaddr", s_awaddr, q_aw.pop_front());
      end
      if (s_wvalid && s_wready) begin
        check("w_expected", q_w.size() != 0, 1);
        if (q_w.size() != 0) check("s_wdata_wstrb", {s_wdata, s_wstrb}, q_w.pop_front());
      end
      if (s_arvalid && s_arready) begin
        check("ar_expected", q_ar.size() != 0, 1);
        if (q_ar.size() != 0) check("s_araddr", s_araddr, q_ar.pop_front());
      end
      if ((m0_bvalid && m0_bready) || (m1_bvalid && m1_bready)) begin
        check("b_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) check("b_owner", m1_bvalid, q_b.pop_front());
        if (m0_bvalid) b0_cyc = cyc;
      end
      if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
        check("r_expected", q_r.size() != 0, 1);
        if (q_r.size() != 0) check("r_owner_data", m1_rvalid ? {1'b1, m1_rdata} : {1'b0, m0_rdata}, q_r.pop_front());
      end
    end
  end
  task automatic m_write(input bit id, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                         input int w_lead, input int bhold);
    bit awd, wd, awhs, whs, bhs;
    int bcnt;
    if (id) begin m1_wdata = d; m1_wstrb = st; m1_wvalid = 1; end
    else begin m0_wdata = d; m0_wstrb = st; m0_wvalid = 1; end
    repeat (w_lead) begin @(posedge clk); #1; end
    if (id) begin m1_awaddr = a; m1_awvalid = 1; end
    else begin m0_awaddr = a; m0_awvalid = 1; end
    awd = 0; wd = 0;
    for (int k = 0; k < 100 && !(awd && wd); k++) begin
      @(negedge clk);
      awhs = id ? (m1_awvalid && m1_awready) : (m0_awvalid && m0_awready);
      whs  = id ? (m1_wvalid && m1_wready) : (m0_wvalid && m0_wready);
      @(posedge clk); #1;
      if (awhs) begin awd = 1; if (id) m1_awvalid = 0; else m0_awvalid = 0; end
      if (whs) begin wd = 1; if (id) m1_wvalid = 0; else m0_wvalid = 0; end
    end
    check("wr_aw_w_done", {awd, wd}, 2'b11);
    if (id) begin m1_awvalid = 0; m1_wvalid = 0; m1_bready = (bhold == 0); end
    else begin m0_awvalid = 0; m0_wvalid = 0; m0_bready = (bhold == 0); end
    bhs = 0; bcnt = 0;
    for (int k = 0; k < 100 && !bhs; k++) begin
      @(negedge clk);
      if (id ? (m1_bvalid && m1_bready) : (m0_bvalid && m0_bready)) bhs = 1;
      else if (id ? m1_bvalid : m0_bvalid) bcnt++;
      @(posedge clk); #1;
      if (bhs || bcnt >= bhold) begin if (id) m1_bready = !bhs; else m0_bready = !bhs; end
    end
    if (id) m1_bready = 0; else m0_bready = 0;
    check("wr_b_done", bhs, 1);
  endtask
  task automatic m_read(input bit id, input logic [31:0] a);
    bit arhs, rhs;
    if (id) begin m1_araddr = a; m1_arvalid = 1; end
    else begin m0_araddr = a; m0_arvalid = 1; end
    arhs = 0;
    for (int k = 0; k < 100 && !arhs; k++) begin
      @(negedge clk);
      arhs = id ? (m1_arvalid && m1_arready) : (m0_arvalid && m0_arready);
      @(posedge clk); #1;
    end
    check("rd_ar_done", arhs, 1);
    if (id) begin m1_arvalid = 0; m1_rready = 1; end
    else begin m0_arvalid = 0; m0_rready = 1; end
    rhs = 0;
    for (int k = 0; k < 100 && !rhs; k++) begin
      @(negedge clk);
      rhs = id ? (m1_rvalid && m1_rready) : (m0_rvalid && m0_rready);
      @(posedge clk); #1;
    end
    if (id) m1_rready = 0; else m0_rready = 0;
    check("rd_r_done", rhs, 1);
  endtask
  initial begin
    bit arhs;
    {m0_awaddr, m0_araddr, m0_wdata, m0_wstrb, m1_awaddr, m1_araddr, m1_wdata, m1_wstrb} = '0;
    {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready} = '0;
    {m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant_o, 2'b00);
    check("rst_outputs", all_vr(), 0);
    rst_n = 1;
    @(posedge clk); #1;
    // single m0 write, slave always ready
    q_g.push_back(2'b01); q_aw.push_back(32'h2000_0010); q_w.push_back({32'hDEAD_BEEF, 4'hF}); q_b.push_back(1'b0);
    fork
      m_write(0, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
      begin
        @(negedge clk);
        check("t1_not_yet_forwarded", {s_awvalid, s_wvalid, grant_o}, 0);
        @(negedge clk);
        check("t1_forwarded", {s_awvalid, s_wvalid, grant_o}, 4'b1101);
      end
    join
    check("t1_grant_released", grant_o, 2'b00);
    // m1 read with delayed R
    r_delay = 3; rd_val = 32'h1234_5678;
    q_g.push_back(2'b10); q_ar.push_back(32'h2000_0004); q_r.push_back({1'b1, 32'h1234_5678});
    m_read(1, 32'h2000_0004);
    // W leads AW by 2 cycles, slave stalls AW 3 cycles
    aw_stall = 3;
    q_g.push_back(2'b01); q_aw.push_back(32'h2000_0020); q_w.push_back({32'hCAFE_F00D, 4'h3}); q_b.push_back(1'b0);
    m_write(0, 32'h2000_0020, 32'hCAFE_F00D, 4'h3, 2, 0);
    check("t4_aw_stall_used", aw_stall, 0);
    // m0 holds bready low 5 cycles while m1 waits
    r_delay = 1; rd_val = 32'h5555_AAAA;
    q_g.push_back(2'b01); q_g.push_back(2'b10);
    q_aw.push_back(32'h2000_0030); q_w.push_back({32'h1122_3344, 4'hF}); q_b.push_back(1'b0);
    q_ar.push_back(32'h2000_0034); q_r.push_back({1'b1, 32'h5555_AAAA});
    fork
      m_write(0, 32'h2000_0030, 32'h1122_3344, 4'hF, 0, 5);
      begin
        repeat (2) begin @(posedge clk); #1; end
        m_read(1, 32'h2000_0034);
      end
    join
    check("t5_m1_grant_after_b", g1_cyc - b0_cyc, 2);
    // fairness after reset: simultaneous reads alternate m0, m1
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    r_delay = 0;
    for (int i = 0; i < 4; i++) begin
      rd_val = 32'hA5A5_0000 + i;
      q_g.push_back(2'b01); q_g.push_back(2'b10);
      q_ar.push_back(32'h2000_0040 + 8 * i); q_ar.push_back(32'h2000_0044 + 8 * i);
      q_r.push_back({1'b0, rd_val}); q_r.push_back({1'b1, rd_val});
      fork
        m_read(0, 32'h2000_0040 + 8 * i);
        m_read(1, 32'h2000_0044 + 8 * i);
      join
    end
    // reset during RD_DATA, then a fresh m1 read
    r_delay = 20;
    q_g.push_back(2'b10); q_ar.push_back(32'h2000_0050);
    m1_araddr = 32'h2000_0050; m1_arvalid = 1; arhs = 0;
    for (int k = 0; k < 50 && !arhs; k++) begin
      @(negedge clk);
      arhs = m1_arvalid && m1_arready;
      @(posedge clk); #1;
    end
    check("t6_ar_done", arhs, 1);
    m1_arvalid = 0; m1_rready = 1;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("t6_rst_grant", grant_o, 2'b00);
    check("t6_rst_outputs", all_vr(), 0);
    m1_rready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    r_delay = 2; rd_val = 32'h0BAD_CAFE;
    q_g.push_back(2'b10); q_ar.push_back(32'h2000_0060); q_r.push_back({1'b1, 32'h0BAD_CAFE});
    m_read(1, 32'h2000_0060);
    repeat (3) @(posedge clk);
    check("queues_drained", q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size() + q_g.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
